// File: rtl/periph_int_ctrl_pkg.sv
// Shared definitions for the peripheral interrupt controller: register
// offsets, FSM state encoding and default code width.
package periph_int_ctrl_pkg;

  localparam int unsigned INT_CODE_WIDTH = 5;
  localparam int unsigned REG_ADDR_W     = 4;
  localparam int unsigned REG_DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] INTC_REG_ENABLE  = 4'h0;
  localparam logic [REG_ADDR_W-1:0] INTC_REG_PENDING = 4'h4;
  localparam logic [REG_ADDR_W-1:0] INTC_REG_TRIGGER = 4'h8;
  localparam logic [REG_ADDR_W-1:0] INTC_REG_CLAIM   = 4'hC;

  typedef enum logic [1:0] {
    INTC_ST_IDLE       = 2'd0,
    INTC_ST_ASSERT     = 2'd1,
    INTC_ST_IN_SERVICE = 2'd2
  } intc_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: lowest set request index i yields code i+1.
module intc_prio_enc #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned CODE_W  = 5
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [CODE_W-1:0]  code_c,
  output logic               valid_c
);

  // Scan from the top so the lowest index is written last and wins.
  always_comb begin
    code_c  = '0;
    valid_c = 1'b0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        code_c  = CODE_W'(i + 1);
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_int_ctrl.sv
// Peripheral interrupt controller with claim/complete handshake feeding the
// machine-mode CSR code input. Define INTC_SYNC_EN for 2-flop input synchronizers.
module periph_int_ctrl
  import periph_int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned CODE_W  = INT_CODE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC-1:0]    irq_src,
  input  logic [REG_ADDR_W-1:0] reg_addr,
  input  logic [REG_DATA_W-1:0] reg_wdata,
  input  logic                  reg_we,
  input  logic                  reg_re,
  output logic [REG_DATA_W-1:0] reg_rdata,
  output logic [CODE_W-1:0]     peripheral_int_code
);

  intc_state_e         state, state_nxt;
  logic [NUM_SRC-1:0]  enable, trigger, pending, pending_nxt;
  logic [NUM_SRC-1:0]  irq_cond, irq_prev;
  logic [CODE_W-1:0]   cur_code, win_code_c, code_nxt_c;
  logic [REG_DATA_W-1:0] rdata_c;
  logic                win_valid_c, cur_active_c, load_cur_c, claim_clr_c;
  logic                rd_claim_c, wr_claim_c, complete_c;
  logic                unused_wdata;

  assign unused_wdata = ^reg_wdata;

`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_cond = sync_q2;
`else
  assign irq_cond = irq_src;
`endif

  assign rd_claim_c = reg_re && (reg_addr == INTC_REG_CLAIM);
  assign wr_claim_c = reg_we && (reg_addr == INTC_REG_CLAIM);
  assign complete_c = wr_claim_c && (reg_wdata[CODE_W-1:0] == cur_code);

  intc_prio_enc #(.NUM_SRC(NUM_SRC), .CODE_W(CODE_W)) u_prio_enc (
    .req     (pending & enable),
    .code_c  (win_code_c),
    .valid_c (win_valid_c)
  );

  // Edge sources: a new rising edge beats a same-cycle claim clear.
  always_comb begin
    pending_nxt  = '0;
    cur_active_c = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (trigger[i])
        pending_nxt[i] = (irq_cond[i] & ~irq_prev[i]) |
                         (pending[i] & ~(claim_clr_c && (cur_code == CODE_W'(i + 1))));
      else
        pending_nxt[i] = irq_cond[i];
      if ((cur_code == CODE_W'(i + 1)) && pending[i] && enable[i])
        cur_active_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INTC_ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INTC_ST_IDLE:       if (win_valid_c) state_nxt = INTC_ST_ASSERT;
      INTC_ST_ASSERT: begin
        if (rd_claim_c)         state_nxt = INTC_ST_IN_SERVICE;
        else if (!cur_active_c) state_nxt = INTC_ST_IDLE;
      end
      INTC_ST_IN_SERVICE: if (complete_c) state_nxt = INTC_ST_IDLE;
      default:            state_nxt = INTC_ST_IDLE;
    endcase
  end

  always_comb begin
    load_cur_c  = 1'b0;
    claim_clr_c = 1'b0;
    code_nxt_c  = '0;
    case (state)
      INTC_ST_IDLE: begin
        load_cur_c = win_valid_c;
        code_nxt_c = win_valid_c ? win_code_c : '0;
      end
      INTC_ST_ASSERT: begin
        claim_clr_c = rd_claim_c;
        code_nxt_c  = (!rd_claim_c && cur_active_c) ? cur_code : '0;
      end
      default: code_nxt_c = '0;
    endcase
  end

  // Read mux sees pre-write register values.
  always_comb begin
    rdata_c = '0;
    case (reg_addr)
      INTC_REG_ENABLE:  rdata_c = REG_DATA_W'(enable);
      INTC_REG_PENDING: rdata_c = REG_DATA_W'(pending);
      INTC_REG_TRIGGER: rdata_c = REG_DATA_W'(trigger);
      INTC_REG_CLAIM:   rdata_c = (state == INTC_ST_ASSERT) ? REG_DATA_W'(cur_code) : '0;
      default:          rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable              <= '0;
      trigger             <= '0;
      pending             <= '0;
      irq_prev            <= '0;
      cur_code            <= '0;
      peripheral_int_code <= '0;
      reg_rdata           <= '0;
    end else begin
      irq_prev            <= irq_cond;
      pending             <= pending_nxt;
      peripheral_int_code <= code_nxt_c;
      if (load_cur_c) cur_code <= win_code_c;
      if (reg_re)     reg_rdata <= rdata_c;
      if (reg_we && (reg_addr == INTC_REG_ENABLE))  enable  <= reg_wdata[NUM_SRC-1:0];
      if (reg_we && (reg_addr == INTC_REG_TRIGGER)) trigger <= reg_wdata[NUM_SRC-1:0];
    end
  end

endmodule
